// File: rtl/mash_pkg.sv
// Shared constants and types for the MASH CIC decimator (default build widths).
package mash_pkg;

  localparam int MASH_IN_W       = 4;
  localparam int MASH_CIC_ORDER  = 3;
  localparam int MASH_CIC_R_LOG2 = 4;

  function automatic int cic_out_w(input int in_w, input int order, input int r_log2);
    return in_w + order * r_log2;
  endfunction

  localparam int MASH_CIC_OUT_W = cic_out_w(MASH_IN_W, MASH_CIC_ORDER, MASH_CIC_R_LOG2);

  typedef logic signed [MASH_CIC_OUT_W-1:0] cic_sample_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One registered M=1 differentiator of the CIC comb chain; the token marks a
// decimated sample travelling down the pipeline.
module cic_comb_stage #(
  parameter int W = 16
) (
  input  logic                clck,
  input  logic                rst,
  input  logic                tok_in,
  input  logic signed [W-1:0] din,
  output logic                tok_out,
  output logic signed [W-1:0] dout
);

  logic                tok_q, tok_d;
  logic signed [W-1:0] dly_q, dly_d;
  logic signed [W-1:0] out_q, out_d;

  // Difference against the previous decimated input, only when a token arrives.
  always_comb begin
    tok_d = tok_in;
    dly_d = dly_q;
    out_d = out_q;
    if (tok_in) begin
      dly_d = din;
      out_d = din - dly_q;
    end else begin
      dly_d = dly_q;
      out_d = out_q;
    end
  end

  // State registers.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      tok_q <= 1'b0;
      dly_q <= '0;
      out_q <= '0;
    end else begin
      tok_q <= tok_d;
      dly_q <= dly_d;
      out_q <= out_d;
    end
  end

  assign tok_out = tok_q;
  assign dout    = out_q;

endmodule

// File: rtl/mash_cic_decimator.sv
// sinc^ORDER decimator turning the 4-bit MASH stream back into PCM words.
// Optional macro MASH_CIC_GAIN_NORM_EN scales output back to input range.
module mash_cic_decimator
  import mash_pkg::*;
#(
  parameter int IN_W   = MASH_IN_W,
  parameter int ORDER  = MASH_CIC_ORDER,
  parameter int R_LOG2 = MASH_CIC_R_LOG2
) (
  input  logic                                        clck,
  input  logic                                        rst,
  input  logic [IN_W-1:0]                             x,
  input  logic                                        in_valid,
  output logic [cic_out_w(IN_W, ORDER, R_LOG2)-1:0]   y,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        overrun
);

  localparam int OUT_W = cic_out_w(IN_W, ORDER, R_LOG2);
  localparam int SHIFT = ORDER * R_LOG2;

  logic signed [OUT_W-1:0] integ_q [ORDER];
  logic signed [OUT_W-1:0] integ_d [ORDER];
  logic [R_LOG2-1:0]       cnt_q, cnt_d;
  logic                    strobe_q, strobe_d;
  logic signed [OUT_W-1:0] x_ext_s;
  logic                    tok_s  [ORDER+1];
  logic signed [OUT_W-1:0] comb_s [ORDER+1];
  logic signed [OUT_W-1:0] word_s;
  logic signed [OUT_W-1:0] y_q, y_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;

  assign x_ext_s = {{(OUT_W-IN_W){x[IN_W-1]}}, x};

  // Cascaded integrators (modular arithmetic) and decimation phase counter.
  always_comb begin
    integ_d  = integ_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + x_ext_s;
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_d[k-1];
      end
      cnt_d    = cnt_q + R_LOG2'(1);
      strobe_d = &cnt_q;
    end else begin
      integ_d  = integ_q;
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
    end
  end

  // Integrator and counter registers.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
      end
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      integ_q  <= integ_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign tok_s[0]  = strobe_q;
  assign comb_s[0] = integ_q[ORDER-1];

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    cic_comb_stage #(.W(OUT_W)) u_stage (
      .clck    (clck),
      .rst     (rst),
      .tok_in  (tok_s[g]),
      .din     (comb_s[g]),
      .tok_out (tok_s[g+1]),
      .dout    (comb_s[g+1])
    );
  end

`ifdef MASH_CIC_GAIN_NORM_EN
  assign word_s = comb_s[ORDER] >>> SHIFT;
`else
  assign word_s = comb_s[ORDER];
`endif

  // Output holding register; a result arriving while the word is still
  // unconsumed is discarded and flagged rather than stalling the comb chain.
  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (tok_s[ORDER]) begin
      if (!out_valid_q || out_ready) begin
        y_d         = word_s;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      y_d = y_q;
    end
  end

  // Output registers.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/mash_cic_decimator.md
Name: mash_cic_decimator

Overview:
- Receive-side counterpart of the MASH sigma-delta DAC path. Takes the 4-bit signed MASH modulator sample stream and reconstructs wide PCM words with a CIC (sinc^ORDER) decimator, ratio 2^R_LOG2.
- Used as the loopback/verification decoder and as the bitstream-to-PCM reader in the converter test path.
- Output is a valid/ready handshake, one word per R accepted input samples.

Parameters:
- IN_W, 4: input sample width, signed two's complement.
- ORDER, 3: number of integrator and comb stages; legal values 1..4.
- R_LOG2, 4: log2 of the decimation ratio R (default R=16); legal values 1..6.
- OUT_W, IN_W+ORDER*R_LOG2 (16 by default): internal and output width. This is a localparam and is not overridable.

Ports:
- clck, in, 1: single clock. All logic is rising-edge.
- rst, in, 1: asynchronous, active-low reset. Asserted (0) clears all state immediately; deassertion is synchronous to clck by the integrator.
- x, in, IN_W: signed MASH sample.
- in_valid, in, 1: x is valid this cycle. The block never backpressures; every valid sample is accepted.
- y, out, OUT_W: signed decimated output word.
- out_valid, out, 1: y holds an unconsumed word.
- out_ready, in, 1: consumer accepts y when out_valid&&out_ready.
- overrun, out, 1: sticky flag; a decimated word was dropped because the output register was occupied.

Behaviour:
- Reset (rst=0): all integrators, comb delays, comb pipeline registers, decimation counter, y, out_valid and overrun are 0. Reset mid-operation discards partial accumulations and any pending output word. The first word after reset uses a fresh phase.
- Integrators: on each clck edge with in_valid=1, stage0 += sign-extended x, and stage k += updated stage k-1. This is a cascaded form, with one register per stage per accepted sample. With in_valid=0, integrators hold.
- Arithmetic: all integrator and comb arithmetic is OUT_W-bit modular (wrap-around by design; CIC correctness relies on it). No saturation anywhere.
- Decimation counter: R_LOG2 bits, incremented per accepted sample, wrapping R-1->0. The edge accepting the sample with count==R-1 raises a one-cycle decimation strobe on the following cycle, sampling the last integrator.
- Comb section: ORDER registered stages, differential delay M=1. Stage k out = in - previous in, and advances only on the strobe pipeline token.
- Latency: out_valid rises exactly ORDER+1 clck cycles after the edge accepting the R-th sample.
- Comb pipeline throughput: one word per R accepted inputs. The pipeline is never stalled by out_ready.
- Output register, on a comb result:
  - If out_valid=0, or out_ready=1 in the same cycle: load y and hold out_valid=1.
  - Otherwise, drop the new word, keep the old y, and set overrun=1. overrun clears only on reset.
- Handshake: y and out_valid are stable while out_valid&&!out_ready. out_valid falls on the accepting edge unless a new word loads in the same cycle, in which case it stays 1 with the new y.
- Transient: the first ORDER output words after reset are start-up transients. Word index ORDER onward (zero-based) is steady-state. Steady-state gain is R^ORDER (4096 by default).

Optional Feature:
- MASH_CIC_GAIN_NORM_EN
  - Defined: the value loaded into y is the comb result arithmetically shifted right by ORDER*R_LOG2 and sign-extended to OUT_W, returning to input scale (truncation toward -inf).
  - Undefined: y is the raw comb result at gain R^ORDER.
- Port list and latency are identical in both builds.

Decomposition:
- Shared package mash_pkg holds:
  - MASH_IN_W=4, MASH_CIC_ORDER=3, MASH_CIC_R_LOG2=4;
  - function cic_out_w(in_w, order, r_log2);
  - a typedef for the signed OUT_W sample.
- One natural sub-module, cic_comb_stage, instantiated ORDER times via generate: a registered differentiator with token-in/token-out. Integrators stay inline.

Test Plan:
- Reset values: hold rst=0 with random x/in_valid -> y=0, out_valid=0, overrun=0; release, then feed 15 valid samples -> out_valid stays 0.
- DC step: x=+1 on every cycle, out_ready=1, defaults -> first valid 4 cycles after the 16th sample; words #3 onward equal 4096. Repeat with x=-1 -> -4096, x=-8 -> -32768 (no wrap at output).
- Gapped input: x=+1 with in_valid toggling 1/0 -> same word values as the DC step; out_valid spacing equals 16 accepted samples, i.e. 32 cycles.
- Backpressure: out_ready=0 for 40 cycles under DC input -> first word held stable; second word dropped; overrun=1 and remains 1. Then out_ready=1 -> out_valid falls after one transfer and later words resume.
- Reset mid-frame: assert rst after 7 samples of the 2nd frame -> all outputs 0 immediately; the restarted stream reproduces the DC-step sequence from word #0.
- MASH_CIC_GAIN_NORM_EN defined, x=+1 DC -> steady y=1; x=-1 -> y=-1; x=+3 -> y=3.
